hex_scan_driver: RTL and testbench

//  Downstream display stage for the four 4-bit hex values from testgen/top (data0..data3).

---
 rtl/hex_scan_pkg.sv | 22 ++
 rtl/hex_to_7seg.sv | 12 +
 rtl/hex_scan_driver.sv | 136 +++++++++++++
 tb/tb_hex_scan_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the multiplexed 4-digit hex display driver.
// Holds the active-high segment table, the slot index type and the per-slot scan states.
package hex_scan_pkg;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Segment patterns ordered {g,f,e,d,c,b,a}, indexed by hex value
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [3:0] digit_sel(input logic [15:0] word, input slot_t slot);
    return word[{slot, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-high 7-segment pattern; zero latency, no flow control.
// Output polarity is left to the caller.
module hex_to_7seg
  import hex_scan_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[value];

endmodule

// File: rtl/hex_scan_driver.sv
// Double-buffered 4-digit multiplexed 7-segment driver with dead time, blanking and zero suppression.
// Outputs registered, 1 cycle behind the scan position; no backpressure, updates land on frame boundaries.
module hex_scan_driver
  import hex_scan_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [3:0]  data0,
  input  logic [3:0]  data1,
  input  logic [3:0]  data2,
  input  logic [3:0]  data3,
  input  logic [3:0]  blank_en,
  input  logic        lz_suppress,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic [15:0] shown
);

  localparam int               CW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]    CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]    BLANK_END = CW'(BLANK_CYCLES);
  localparam logic             POL       = (ACTIVE_LOW != 0);
  localparam logic [3:0]       AN_OFF    = {4{POL}};
  localparam logic [6:0]       SEG_OFF   = {7{POL}};
  localparam scan_state_t      ST_RESET  = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  slot_t         slot;
  scan_state_t   state;
  logic          wrap;
  logic          frame_end;

  logic [15:0]   din;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          pend_vld;

  logic [3:1]    zero_run;
  logic [3:0]    dark;
  logic [3:0]    an_on;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_hi;

  assign din       = {data3, data2, data1, data0};
  assign wrap      = (cnt == CNT_LAST);
  assign frame_end = wrap && (slot == 2'd3);
  assign cnt_nxt   = wrap ? '0 : cnt + CW'(1);
  assign shown     = active;

  // Pending captures every load; active only moves at the frame boundary, where a
  // simultaneous load bypasses the pending buffer so the newest data is never a frame late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active   <= 16'h0;
      pending  <= 16'h0;
      pend_vld <= 1'b0;
    end else begin
      if (load) begin
        pending <= din;
      end
      if (frame_end) begin
        if (load) begin
          active <= din;
        end else if (pend_vld) begin
          active <= pending;
        end
        pend_vld <= 1'b0;
      end else if (load) begin
        pend_vld <= 1'b1;
      end
    end
  end

  // zero_run[i]: active digits i..3 are all zero
  always_comb begin
    zero_run[3] = (active[15:12] == 4'h0);
    zero_run[2] = zero_run[3] && (active[11:8] == 4'h0);
    zero_run[1] = zero_run[2] && (active[7:4] == 4'h0);
    dark[0]     = blank_en[0];
    dark[1]     = blank_en[1] || (lz_suppress && zero_run[1]);
    dark[2]     = blank_en[2] || (lz_suppress && zero_run[2]);
    dark[3]     = blank_en[3] || (lz_suppress && zero_run[3]);
  end

  assign cur_digit = digit_sel(active, slot);
  assign an_on     = 4'b0001 << slot;

  hex_to_7seg u_dec (
    .value (cur_digit),
    .seg   (seg_hi)
  );

  // Scan counter, slot FSM and output registers; state tracks the phase of the current cnt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      slot       <= 2'd0;
      state      <= ST_RESET;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (wrap) begin
        slot <= slot + 2'd1;
      end
      state <= (cnt_nxt < BLANK_END) ? BLANK : DRIVE;

      case (state)
        DRIVE: begin
          if (!dark[slot]) begin
            an  <= an_on ^ AN_OFF;
            seg <= seg_hi ^ SEG_OFF;
          end else begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
          end
        end
        default: begin
          an  <= AN_OFF;
          seg <= SEG_OFF;
        end
      endcase

      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with an 8-cycle slot and 2 dead-time cycles.
// Samples on the falling edge; capture index j (1..32) after a frame_done holds slot (j-1)/8, cnt (j-1)%8.
module tb_hex_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [3:0]  data0, data1, data2, data3;
  logic [3:0]  blank_en;
  logic        lz_suppress;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic [15:0] shown;

  int errors = 0;
  int checks = 0;

  logic [3:0] an_s  [33];
  logic [6:0] seg_s [33];

  always #5 clk = ~clk;

  hex_scan_driver #(
    .PRESCALE     (8),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .data0       (data0),
    .data1       (data1),
    .data2       (data2),
    .data3       (data3),
    .blank_en    (blank_en),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .an          (an),
    .frame_done  (frame_done),
    .shown       (shown)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_word(input logic [15:0] w);
    {data3, data2, data1, data0} = w;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic capture_frame();
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      an_s[j]  = an;
      seg_s[j] = seg;
    end
  endtask

  function automatic logic [3:0] lit_mask();
    logic [3:0] m;
    m = 4'b0000;
    for (int j = 1; j <= 32; j++) m |= ~an_s[j];
    return m;
  endfunction

  initial begin
    int nfd;
    int first;

    reset_n     = 1'b0;
    load        = 1'b0;
    data0       = 4'h0;
    data1       = 4'h0;
    data2       = 4'h0;
    data3       = 4'h0;
    blank_en    = 4'b0000;
    lz_suppress = 1'b0;

    // 1. reset state, release latency and frame period
    step(3);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_shown", {16'd0, shown}, 32'h0);
    reset_n = 1'b1;
    nfd   = 0;
    first = 0;
    for (int i = 1; i <= 96; i++) begin
      @(negedge clk);
      if (i == 1) chk("rel_an_1", {28'd0, an}, 32'hF);
      if (i == 2) chk("rel_an_2", {28'd0, an}, 32'hF);
      if (i == 3) chk("rel_an_3", {28'd0, an}, 32'hE);
      if (frame_done) begin
        nfd++;
        if (first == 0) first = i;
      end
    end
    chk("fd_first", first, 32);
    chk("fd_count", nfd, 3);

    // 2. mid-frame load is held back until the frame boundary
    load_word(16'h1234);
    chk("mid_shown_a", {16'd0, shown}, 32'h0);
    step(10);
    chk("mid_shown_b", {16'd0, shown}, 32'h0);
    wait_fd("t2_fd");
    chk("t2_shown", {16'd0, shown}, 32'h1234);
    capture_frame();
    chk("t2_blank_an", {28'd0, an_s[1]}, 32'hF);
    chk("t2_s0_an", {28'd0, an_s[3]}, 32'hE);
    chk("t2_s0_seg", {25'd0, seg_s[3]}, 32'b0011001);
    chk("t2_s1_seg", {25'd0, seg_s[11]}, 32'b0110000);
    chk("t2_s3_an", {28'd0, an_s[27]}, 32'h7);
    chk("t2_s3_seg", {25'd0, seg_s[27]}, 32'b1111001);

    // 3. leading-zero suppression
    lz_suppress = 1'b1;
    load_word(16'h0050);
    wait_fd("t3_fd_a");
    chk("t3_shown", {16'd0, shown}, 32'h0050);
    capture_frame();
    chk("t3_lit", {28'd0, lit_mask()}, 32'h3);
    chk("t3_d1_an", {28'd0, an_s[11]}, 32'hD);
    chk("t3_d1_seg", {25'd0, seg_s[11]}, 32'b0010010);
    chk("t3_d0_seg", {25'd0, seg_s[3]}, 32'b1000000);
    load_word(16'h0000);
    wait_fd("t3_fd_b");
    capture_frame();
    chk("t3_zero_lit", {28'd0, lit_mask()}, 32'h1);
    chk("t3_zero_seg", {25'd0, seg_s[3]}, 32'b1000000);
    lz_suppress = 1'b0;

    // 4. per-digit blanking
    blank_en = 4'b0100;
    load_word(16'h8888);
    wait_fd("t4_fd");
    capture_frame();
    chk("t4_lit", {28'd0, lit_mask()}, 32'hB);
    chk("t4_s2_an", {28'd0, an_s[19]}, 32'hF);
    chk("t4_s0_seg", {25'd0, seg_s[3]}, 32'h0);
    chk("t4_s1_seg", {25'd0, seg_s[11]}, 32'h0);
    chk("t4_s3_seg", {25'd0, seg_s[27]}, 32'h0);
    blank_en = 4'b0000;

    // 5. last load wins; a load on the boundary cycle bypasses pending
    load_word(16'hAAAA);
    step(5);
    load_word(16'hBBBB);
    wait_fd("t5_fd_a");
    chk("t5_lastwins", {16'd0, shown}, 32'hBBBB);
    step(31);
    chk("t5_pre_fd", {31'd0, frame_done}, 32'd0);
    chk("t5_pre_shown", {16'd0, shown}, 32'hBBBB);
    {data3, data2, data1, data0} = 16'hCCCC;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("t5_bnd_fd", {31'd0, frame_done}, 32'd1);
    chk("t5_bypass", {16'd0, shown}, 32'hCCCC);
    capture_frame();
    chk("t5_seg_c", {25'd0, seg_s[3]}, 32'b1000110);
    chk("t5_fd_end", {31'd0, frame_done}, 32'd1);

    // 6. asynchronous reset during slot 2 drive
    step(19);
    chk("t6_pre_an", {28'd0, an}, 32'hB);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_an", {28'd0, an}, 32'hF);
    chk("t6_async_seg", {25'd0, seg}, 32'h7F);
    chk("t6_async_shown", {16'd0, shown}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      @(negedge clk);
      if (i == 2) chk("t6_rel_an_2", {28'd0, an}, 32'hF);
      if (i == 3) begin
        chk("t6_rel_an_3", {28'd0, an}, 32'hE);
        chk("t6_rel_seg_3", {25'd0, seg}, 32'b1000000);
      end
      if (frame_done) first = i;
    end
    chk("t6_restart_fd", first, 32);
    chk("t6_shown", {16'd0, shown}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
